// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared mode codes, frame geometry and FSM state type
package vga_pkg;

  localparam logic [2:0] MODE_NONE    = 3'd0;
  localparam logic [2:0] MODE_BLUR    = 3'd1;
  localparam logic [2:0] MODE_SHARPEN = 3'd2;
  localparam logic [2:0] MODE_EDGE    = 3'd3;
  localparam logic [2:0] MODE_OUTLINE = 3'd4;

  localparam int NUM_MODES    = 5;
  localparam int IMG_W        = 320;
  localparam int IMG_H        = 240;
  localparam int FRAME_PIXELS = IMG_W * IMG_H;

  typedef enum logic {
    ST_RUN     = 1'b0,
    ST_PENDING = 1'b1
  } mode_state_e;

endpackage

// File: rtl/frame_monitor.sv
// rtl/frame_monitor.sv - pixel position tracking, framing-error flag and frame counter
module frame_monitor #(
  parameter int FRAME_PIXELS = vga_pkg::FRAME_PIXELS
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        hs,
  input  logic        st_sop,
  input  logic        st_eop,
  input  logic        err_clr,
  output logic        boundary,
  output logic [15:0] frame_cnt,
  output logic        sync_err
);

  localparam logic [16:0] LAST_PIX = 17'(FRAME_PIXELS - 1);

  logic [16:0] pixel_cnt_q, pixel_cnt_d;
  logic [15:0] frame_cnt_q, frame_cnt_d;
  logic        sync_err_q, sync_err_d;
  logic        frame_err;

  always_comb begin
    boundary    = hs && st_eop;
    frame_err   = hs && ((st_sop && (pixel_cnt_q != 17'd0)) ||
                         (st_eop && (pixel_cnt_q != LAST_PIX)));
    pixel_cnt_d = pixel_cnt_q;
    // Markers always realign the count, which also resynchronises after an error.
    if (hs) begin
      if (st_eop)                       pixel_cnt_d = 17'd0;
      else if (st_sop)                  pixel_cnt_d = 17'd1;
      else if (pixel_cnt_q == LAST_PIX) pixel_cnt_d = 17'd0;
      else                              pixel_cnt_d = pixel_cnt_q + 17'd1;
    end
    frame_cnt_d = frame_cnt_q + {15'd0, boundary};
    sync_err_d  = frame_err || (sync_err_q && !err_clr);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pixel_cnt_q <= 17'd0;
      frame_cnt_q <= 16'd0;
      sync_err_q  <= 1'b0;
    end else begin
      pixel_cnt_q <= pixel_cnt_d;
      frame_cnt_q <= frame_cnt_d;
      sync_err_q  <= sync_err_d;
    end
  end

  assign frame_cnt = frame_cnt_q;
  assign sync_err  = sync_err_q;

endmodule

// File: rtl/frame_mode_ctrl.sv
// rtl/frame_mode_ctrl.sv - frame-synchronous filter mode switching with auto-cycling
module frame_mode_ctrl #(
  parameter int NUM_MODES    = vga_pkg::NUM_MODES,
  parameter int FRAME_PIXELS = vga_pkg::FRAME_PIXELS,
  parameter int AUTO_FRAMES  = 60
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  mode_req,
  input  logic        mode_req_valid,
  input  logic        auto_en,
  input  logic        err_clr,
  input  logic        st_valid,
  input  logic        st_ready,
  input  logic        st_sop,
  input  logic        st_eop,
  output logic [2:0]  filter_mode,
  output logic        mode_pending,
  output logic        mode_ack,
  output logic        mode_nack,
  output logic [15:0] frame_cnt,
  output logic        sync_err
);
  import vga_pkg::*;

  localparam logic [3:0]  MODE_LIMIT = 4'(NUM_MODES);
  localparam logic [2:0]  LAST_MODE  = 3'(NUM_MODES - 1);
  localparam logic [15:0] AUTO_LAST  = 16'(AUTO_FRAMES - 1);

  mode_state_e state_q, state_d;
  logic [2:0]  filter_mode_q, filter_mode_d;
  logic [2:0]  latch_q, latch_d;
  logic        mode_ack_q, mode_ack_d;
  logic        mode_nack_q, mode_nack_d;
  logic [15:0] auto_cnt_q, auto_cnt_d;

  logic        hs, boundary, auto_fire, req_v, req_legal, applied;
  logic [2:0]  req_mode, auto_mode, target;

  assign hs = st_valid && st_ready;

  frame_monitor #(.FRAME_PIXELS(FRAME_PIXELS)) u_monitor (
    .clk       (clk),
    .reset     (reset),
    .hs        (hs),
    .st_sop    (st_sop),
    .st_eop    (st_eop),
    .err_clr   (err_clr),
    .boundary  (boundary),
    .frame_cnt (frame_cnt),
    .sync_err  (sync_err)
  );

  always_comb begin
    auto_mode = (filter_mode_q == LAST_MODE) ? 3'd0 : filter_mode_q + 3'd1;
    // The auto request fires on the boundary itself so it is applied at that same edge.
    auto_fire = (state_q == ST_RUN) && auto_en && boundary && (auto_cnt_q == AUTO_LAST);
    req_v     = mode_req_valid || auto_fire;
    req_mode  = mode_req_valid ? mode_req : auto_mode;
    req_legal = {1'b0, req_mode} < MODE_LIMIT;

    state_d       = state_q;
    filter_mode_d = filter_mode_q;
    latch_d       = latch_q;
    mode_ack_d    = 1'b0;
    mode_nack_d   = req_v && !req_legal;
    applied       = 1'b0;
    target        = (req_v && req_legal) ? req_mode : latch_q;

    case (state_q)
      ST_RUN: begin
        if (req_v && req_legal) begin
          if (req_mode == filter_mode_q) begin
            mode_ack_d = 1'b1;
          end else if (boundary) begin
            filter_mode_d = req_mode;
            mode_ack_d    = 1'b1;
            applied       = 1'b1;
          end else begin
            latch_d = req_mode;
            state_d = ST_PENDING;
          end
        end
      end
      default: begin
        if (boundary) begin
          filter_mode_d = target;
          mode_ack_d    = 1'b1;
          applied       = 1'b1;
          state_d       = ST_RUN;
        end else begin
          latch_d = target;
        end
      end
    endcase

    auto_cnt_d = auto_cnt_q;
    if (!auto_en || applied || auto_fire)  auto_cnt_d = 16'd0;
    else if (state_q == ST_RUN && boundary) auto_cnt_d = auto_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_RUN;
      filter_mode_q <= MODE_NONE;
      latch_q       <= MODE_NONE;
      mode_ack_q    <= 1'b0;
      mode_nack_q   <= 1'b0;
      auto_cnt_q    <= 16'd0;
    end else begin
      state_q       <= state_d;
      filter_mode_q <= filter_mode_d;
      latch_q       <= latch_d;
      mode_ack_q    <= mode_ack_d;
      mode_nack_q   <= mode_nack_d;
      auto_cnt_q    <= auto_cnt_d;
    end
  end

  assign filter_mode  = filter_mode_q;
  assign mode_pending = (state_q == ST_PENDING);
  assign mode_ack     = mode_ack_q;
  assign mode_nack    = mode_nack_q;

endmodule

// File: tb/tb_frame_mode_ctrl.sv
// tb/tb_frame_mode_ctrl.sv - directed scoreboard bench for frame_mode_ctrl
module tb_frame_mode_ctrl;

  localparam int FP = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  mode_req;
  logic        mode_req_valid, auto_en, err_clr;
  logic        st_valid, st_ready, st_sop, st_eop;
  logic [2:0]  filter_mode;
  logic        mode_pending, mode_ack, mode_nack, sync_err;
  logic [15:0] frame_cnt;

  always #5 clk = ~clk;

  frame_mode_ctrl #(.NUM_MODES(5), .FRAME_PIXELS(FP), .AUTO_FRAMES(2)) dut (
    .clk(clk), .reset(reset), .mode_req(mode_req), .mode_req_valid(mode_req_valid),
    .auto_en(auto_en), .err_clr(err_clr), .st_valid(st_valid), .st_ready(st_ready),
    .st_sop(st_sop), .st_eop(st_eop), .filter_mode(filter_mode), .mode_pending(mode_pending),
    .mode_ack(mode_ack), .mode_nack(mode_nack), .frame_cnt(frame_cnt), .sync_err(sync_err)
  );

  typedef struct {
    string       tag;
    logic [2:0]  fm;
    logic        pend;
    logic [15:0] fc;
    logic        se;
    int          acks;
    int          nacks;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;
  int ack_cnt = 0;
  int nack_cnt = 0;

  always @(posedge clk) begin
    #1;
    if (mode_ack === 1'b1)  ack_cnt++;
    if (mode_nack === 1'b1) nack_cnt++;
  end

  task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  task automatic push(input string tag, input logic [2:0] fm, input logic pend,
                      input logic [15:0] fc, input logic se, input int acks, input int nacks);
    exp_t e;
    e.tag = tag; e.fm = fm; e.pend = pend; e.fc = fc; e.se = se; e.acks = acks; e.nacks = nacks;
    sb.push_back(e);
  endtask

  task automatic chk();
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL scoreboard_empty observed=0 expected=1");
    end else begin
      e = sb.pop_front();
      cmp({e.tag, ".filter_mode"}, 32'(filter_mode), 32'(e.fm));
      cmp({e.tag, ".mode_pending"}, 32'(mode_pending), 32'(e.pend));
      cmp({e.tag, ".frame_cnt"}, 32'(frame_cnt), 32'(e.fc));
      cmp({e.tag, ".sync_err"}, 32'(sync_err), 32'(e.se));
      cmp({e.tag, ".acks"}, ack_cnt, e.acks);
      cmp({e.tag, ".nacks"}, nack_cnt, e.nacks);
    end
  endtask

  task automatic drive_pixel(input logic sop, input logic eop, input logic rv,
                             input logic [2:0] rm, input logic clr);
    st_valid = 1'b1; st_ready = 1'b1; st_sop = sop; st_eop = eop;
    mode_req_valid = rv; mode_req = rm; err_clr = clr;
    @(negedge clk);
    st_valid = 1'b0; st_ready = 1'b0; st_sop = 1'b0; st_eop = 1'b0;
    mode_req_valid = 1'b0; err_clr = 1'b0;
  endtask

  task automatic px(input logic sop, input logic eop);
    drive_pixel(sop, eop, 1'b0, 3'd0, 1'b0);
  endtask

  task automatic send_frame();
    for (int i = 0; i < FP; i++) px(i == 0, i == FP - 1);
  endtask

  task automatic request(input logic [2:0] m);
    mode_req = m; mode_req_valid = 1'b1;
    @(negedge clk);
    mode_req_valid = 1'b0;
  endtask

  task automatic clear_err();
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
  endtask

  initial begin
    reset = 1'b0; mode_req = 3'd0; mode_req_valid = 1'b0; auto_en = 1'b0; err_clr = 1'b0;
    st_valid = 1'b0; st_ready = 1'b0; st_sop = 1'b0; st_eop = 1'b0;
    repeat (3) @(negedge clk);
    push("reset", 3'd0, 1'b0, 16'd0, 1'b0, 0, 0); chk();
    reset = 1'b1;
    @(negedge clk);

    send_frame();
    push("s1_frame", 3'd0, 1'b0, 16'd1, 1'b0, 0, 0); chk();

    for (int i = 0; i < 5; i++) px(i == 0, 1'b0);
    request(3'd3);
    push("s2_pend", 3'd0, 1'b1, 16'd1, 1'b0, 0, 0); chk();
    for (int i = 5; i < FP - 1; i++) px(1'b0, 1'b0);
    push("s2_hold", 3'd0, 1'b1, 16'd1, 1'b0, 0, 0); chk();
    px(1'b0, 1'b1);
    push("s2_apply", 3'd3, 1'b0, 16'd2, 1'b0, 1, 0); chk();
    @(negedge clk);
    push("s2_single_ack", 3'd3, 1'b0, 16'd2, 1'b0, 1, 0); chk();

    px(1'b1, 1'b0);
    request(3'd2);
    request(3'd4);
    request(3'd7);
    push("s3_last_wins_pend", 3'd3, 1'b1, 16'd2, 1'b0, 1, 1); chk();
    for (int i = 1; i < FP - 1; i++) px(1'b0, 1'b0);
    px(1'b0, 1'b1);
    push("s3_apply", 3'd4, 1'b0, 16'd3, 1'b0, 2, 1); chk();
    request(3'd7);
    push("s3_nack_run", 3'd4, 1'b0, 16'd3, 1'b0, 2, 2); chk();
    request(3'd4);
    push("s3_same_mode", 3'd4, 1'b0, 16'd3, 1'b0, 3, 2); chk();
    for (int i = 0; i < FP - 1; i++) px(i == 0, 1'b0);
    drive_pixel(1'b0, 1'b1, 1'b1, 3'd1, 1'b0);
    push("s3_req_at_eop", 3'd1, 1'b0, 16'd4, 1'b0, 4, 2); chk();

    for (int i = 0; i < 5; i++) px(i == 0, 1'b0);
    px(1'b0, 1'b1);
    push("s5_early_eop", 3'd1, 1'b0, 16'd5, 1'b1, 4, 2); chk();
    send_frame();
    push("s5_sticky", 3'd1, 1'b0, 16'd6, 1'b1, 4, 2); chk();
    clear_err();
    push("s5_clear", 3'd1, 1'b0, 16'd6, 1'b0, 4, 2); chk();
    for (int i = 0; i < 3; i++) px(i == 0, 1'b0);
    drive_pixel(1'b1, 1'b0, 1'b0, 3'd0, 1'b1);
    push("s5_err_beats_clr", 3'd1, 1'b0, 16'd6, 1'b1, 4, 2); chk();
    clear_err();
    for (int i = 1; i < FP - 1; i++) px(1'b0, 1'b0);
    px(1'b0, 1'b1);
    push("s5_resync", 3'd1, 1'b0, 16'd7, 1'b0, 4, 2); chk();

    request(3'd0);
    send_frame();
    push("s4_start", 3'd0, 1'b0, 16'd8, 1'b0, 5, 2); chk();
    auto_en = 1'b1;
    for (int f = 1; f <= 10; f++) begin
      send_frame();
      push($sformatf("s4_auto_f%0d", f), 3'((f / 2) % 5), 1'b0, 16'(8 + f), 1'b0, 5 + f / 2, 2);
      chk();
    end
    auto_en = 1'b0;

    request(3'd2);
    push("s6_pend", 3'd0, 1'b1, 16'd18, 1'b0, 10, 2); chk();
    px(1'b1, 1'b0);
    for (int i = 0; i < 6; i++) begin
      st_valid = 1'b1; st_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    #2 reset = 1'b0;
    #1;
    cmp("s6_rst.mode_ack", 32'(mode_ack), 32'd0);
    cmp("s6_rst.mode_nack", 32'(mode_nack), 32'd0);
    push("s6_rst", 3'd0, 1'b0, 16'd0, 1'b0, 10, 2); chk();
    st_valid = 1'b0; st_ready = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    send_frame();
    push("s6_no_late_ack", 3'd0, 1'b0, 16'd1, 1'b0, 10, 2); chk();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
